// File: rtl/memory_access_arbiter.sv
// Two-requester sequencer for the shared A/RAM block: IDLE -> LOAD_A -> ACCESS -> RESP per grant, done in RESP.
// Latency: done in the 3rd cycle after the IDLE sample; no backpressure -- a requester holds req until its done.
module memory_access_arbiter #(
  parameter int WIDTH      = 16,
  parameter int PRIO_RESET = 0
) (
  input  logic             cl,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_a,
  output logic             mem_addr_a,
  output logic [WIDTH-1:0] mem_X,
  input  logic [WIDTH-1:0] mem_addr_A
);

  typedef enum logic [1:0] {IDLE, LOAD_A, ACCESS, RESP} state_t;

  // last_q holds the id granted most recently; reset to the opposite of PRIO_RESET so it wins first.
  localparam logic LAST_RESET = (PRIO_RESET == 0);

  state_t           state_q, state_d;
  logic             id_q, id_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             mem_a_q, mem_a_d, mem_addr_a_q, mem_addr_a_d;
  logic [WIDTH-1:0] mem_x_q, mem_x_d;
  logic             win;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    win     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win     = (req0 && req1) ? ~last_q : req1;
          id_d    = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          state_d = LOAD_A;
        end
      end
      LOAD_A: state_d = ACCESS;
      ACCESS: begin
        if (!we_q) rdata_d = mem_addr_A;
        state_d = RESP;
      end
      RESP: begin
        last_d  = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    gnt0_d       = (state_d != IDLE) && !id_d;
    gnt1_d       = (state_d != IDLE) && id_d;
    done0_d      = (state_d == RESP) && !id_d;
    done1_d      = (state_d == RESP) && id_d;
    mem_a_d      = (state_d == LOAD_A);
    mem_addr_a_d = (state_d == ACCESS) && we_d;
    if (state_d == LOAD_A)
      mem_x_d = addr_d;
    else if ((state_d == ACCESS) && we_d)
      mem_x_d = wdata_d;
    else
      mem_x_d = '0;
  end

  always_ff @(posedge cl or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_q       <= LAST_RESET;
      rdata_q      <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      mem_a_q      <= 1'b0;
      mem_addr_a_q <= 1'b0;
      mem_x_q      <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
      rdata_q      <= rdata_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      mem_a_q      <= mem_a_d;
      mem_addr_a_q <= mem_addr_a_d;
      mem_x_q      <= mem_x_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign rdata      = rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_addr_a = mem_addr_a_q;
  assign mem_X      = mem_x_q;

endmodule
